// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle MIPS control unit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       beq;
        logic       bne;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Instruction-class dispatch out of DECODE; unknown opcodes trap.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:    return MEMADR;
            OP_RTYPE:        return EXEC;
            OP_BEQ, OP_BNE:  return BRANCH;
            OP_ADDI, OP_ORI: return IEXEC;
            OP_J:            return JUMP;
            default:         return TRAP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_out_dec.sv
// ============================================================================
// Module      : mc_out_dec
// Description : Moore output decoder: state + latched opcode -> control word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_out_dec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = ready;
                ctrl.pc_write  = ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                // Write strobe stays up across wait cycles; done only on the ready cycle.
                ctrl.mem_req    = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.beq        = (op_q == OP_BEQ);
                ctrl.bne        = (op_q == OP_BNE);
                ctrl.instr_done = 1'b1;
            end
            IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                if (op_q == OP_ORI) begin
                    ctrl.alu_op   = ALU_OR;
                    ctrl.imm_zext = 1'b1;
                end else begin
                    ctrl.alu_op   = ALU_ADD;
                end
            end
            IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle MIPS control FSM with opcode latch and memory wait
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter bit USE_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic       w_ready;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;

    // Single-cycle memory builds treat every access as completing immediately.
    assign w_ready = USE_READY ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_op <= op;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   if (w_ready) w_next = DECODE;
            DECODE:  w_next = decode_next(op);
            MEMADR:  w_next = (r_op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (w_ready) w_next = MEMWB;
            MEMWR:   if (w_ready) w_next = FETCH;
            EXEC:    w_next = ALUWB;
            IEXEC:   w_next = IWB;
            MEMWB, ALUWB, IWB, BRANCH, JUMP: w_next = FETCH;
            TRAP:    w_next = TRAP;
            default: w_next = FETCH;
        endcase
    end

    mc_out_dec u_out_dec (
        .state (r_state),
        .op_q  (r_op),
        .ready (w_ready),
        .ctrl  (w_ctrl)
    );

    // Reset masks every output so no memory write or PC load can commit under reset.
    assign w_out = reset ? '0 : w_ctrl;

    assign mem_req    = w_out.mem_req;
    assign iord       = w_out.iord;
    assign ir_write   = w_out.ir_write;
    assign mem_write  = w_out.mem_write;
    assign reg_write  = w_out.reg_write;
    assign reg_dst    = w_out.reg_dst;
    assign mem_to_reg = w_out.mem_to_reg;
    assign alu_src_a  = w_out.alu_src_a;
    assign alu_src_b  = w_out.alu_src_b;
    assign imm_zext   = w_out.imm_zext;
    assign alu_op     = w_out.alu_op;
    assign pc_src     = w_out.pc_src;
    assign instr_done = w_out.instr_done;
    assign illegal    = w_out.illegal;
    assign pc_en      = w_out.pc_write | (w_out.beq & zero) | (w_out.bne & ~zero);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed-vector bench for multicycle_ctrl (ready and no-ready builds)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    // Row packing: {reset, mem_ready, zero, op[5:0], expected[17:0]}
    // expected = {mem_req,iord,ir_write,mem_write, reg_write,reg_dst,mem_to_reg,alu_src_a,
    //             alu_src_b[1:0], imm_zext, alu_op[1:0], pc_src[1:0], pc_en,instr_done,illegal}
    localparam logic [17:0] c_idle = 18'b0000_0000_00_0_00_00_000;
    localparam logic [17:0] c_fw   = 18'b1000_0000_01_0_00_00_000;
    localparam logic [17:0] c_fr   = 18'b1010_0000_01_0_00_00_100;
    localparam logic [17:0] c_dec  = 18'b0000_0000_11_0_00_00_000;
    localparam logic [17:0] c_madr = 18'b0000_0001_10_0_00_00_000;
    localparam logic [17:0] c_mrd  = 18'b1100_0000_00_0_00_00_000;
    localparam logic [17:0] c_mwb  = 18'b0000_1010_00_0_00_00_010;
    localparam logic [17:0] c_mwr  = 18'b1101_0000_00_0_00_00_000;
    localparam logic [17:0] c_mwrd = 18'b1101_0000_00_0_00_00_010;
    localparam logic [17:0] c_exe  = 18'b0000_0001_00_0_10_00_000;
    localparam logic [17:0] c_awb  = 18'b0000_1100_00_0_00_00_010;
    localparam logic [17:0] c_brt  = 18'b0000_0001_00_0_01_01_110;
    localparam logic [17:0] c_brn  = 18'b0000_0001_00_0_01_01_010;
    localparam logic [17:0] c_iadd = 18'b0000_0001_10_0_00_00_000;
    localparam logic [17:0] c_iori = 18'b0000_0001_10_1_11_00_000;
    localparam logic [17:0] c_iwb  = 18'b0000_1000_00_0_00_00_010;
    localparam logic [17:0] c_jmp  = 18'b0000_0000_00_0_00_10_110;
    localparam logic [17:0] c_trp  = 18'b0000_0000_00_0_00_00_001;

    localparam logic [5:0] c_rtype = 6'b000000;
    localparam logic [5:0] c_lw    = 6'b100011;
    localparam logic [5:0] c_sw    = 6'b101011;
    localparam logic [5:0] c_beq   = 6'b000100;
    localparam logic [5:0] c_bne   = 6'b000101;
    localparam logic [5:0] c_addi  = 6'b001000;
    localparam logic [5:0] c_ori   = 6'b001101;
    localparam logic [5:0] c_j     = 6'b000010;
    localparam logic [5:0] c_bad   = 6'b111111;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op;
    int         n_vec = 0;
    int         n_err = 0;

    logic       a_mem_req, a_iord, a_ir_write, a_mem_write, a_reg_write, a_reg_dst;
    logic       a_mem_to_reg, a_alu_src_a, a_imm_zext, a_pc_en, a_instr_done, a_illegal;
    logic [1:0] a_alu_src_b, a_alu_op, a_pc_src;
    logic       b_mem_req, b_iord, b_ir_write, b_mem_write, b_reg_write, b_reg_dst;
    logic       b_mem_to_reg, b_alu_src_a, b_imm_zext, b_pc_en, b_instr_done, b_illegal;
    logic [1:0] b_alu_src_b, b_alu_op, b_pc_src;
    logic [17:0] obs_a, obs_b;

    always #5 clk = ~clk;

    // a: handshake build; b: single-cycle-memory build
    multicycle_ctrl #(.USE_READY(1'b1)) dut_a (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .iord(a_iord), .ir_write(a_ir_write), .mem_write(a_mem_write),
        .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .imm_zext(a_imm_zext),
        .alu_op(a_alu_op), .pc_src(a_pc_src), .pc_en(a_pc_en),
        .instr_done(a_instr_done), .illegal(a_illegal)
    );

    multicycle_ctrl #(.USE_READY(1'b0)) dut_b (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .iord(b_iord), .ir_write(b_ir_write), .mem_write(b_mem_write),
        .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .imm_zext(b_imm_zext),
        .alu_op(b_alu_op), .pc_src(b_pc_src), .pc_en(b_pc_en),
        .instr_done(b_instr_done), .illegal(b_illegal)
    );

    assign obs_a = {a_mem_req, a_iord, a_ir_write, a_mem_write, a_reg_write, a_reg_dst,
                    a_mem_to_reg, a_alu_src_a, a_alu_src_b, a_imm_zext, a_alu_op, a_pc_src,
                    a_pc_en, a_instr_done, a_illegal};
    assign obs_b = {b_mem_req, b_iord, b_ir_write, b_mem_write, b_reg_write, b_reg_dst,
                    b_mem_to_reg, b_alu_src_a, b_alu_src_b, b_imm_zext, b_alu_op, b_pc_src,
                    b_pc_en, b_instr_done, b_illegal};

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = c_bne;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if (obs_a !== c_idle) begin
                n_err++; $display("FAIL reset_a cyc %0d: got %b want %b", k, obs_a, c_idle);
            end
            n_vec++;
            if (obs_b !== c_idle) begin
                n_err++; $display("FAIL reset_b cyc %0d: got %b want %b", k, obs_b, c_idle);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_noready();
        logic [26:0] t [$];
        t.push_back({1'b1, 1'b0, 1'b0, c_rtype, c_idle});
        t.push_back({1'b0, 1'b0, 1'b0, c_rtype, c_fr});
        t.push_back({1'b0, 1'b0, 1'b0, c_rtype, c_dec});
        t.push_back({1'b0, 1'b0, 1'b0, c_rtype, c_exe});
        t.push_back({1'b0, 1'b0, 1'b0, c_rtype, c_awb});
        t.push_back({1'b0, 1'b0, 1'b0, c_rtype, c_fr});
        foreach (t[k]) begin
            {reset, mem_ready, zero, op} = t[k][26:18];
            @(negedge clk);
            n_vec++;
            if (obs_b !== t[k][17:0]) begin
                n_err++; $display("FAIL rtype row %0d: got %b want %b", k, obs_b, t[k][17:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_waits();
        logic [26:0] t [$];
        t.push_back({1'b1, 1'b0, 1'b0, c_lw, c_idle});
        t.push_back({1'b0, 1'b0, 1'b0, c_lw, c_fw});
        t.push_back({1'b0, 1'b0, 1'b0, c_lw, c_fw});
        t.push_back({1'b0, 1'b1, 1'b0, c_lw, c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_lw, c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_madr});   // op change after DECODE must be ignored
        t.push_back({1'b0, 1'b0, 1'b0, c_sw, c_mrd});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_mrd});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_mwb});
        t.push_back({1'b0, 1'b0, 1'b0, c_sw, c_fw});
        foreach (t[k]) begin
            {reset, mem_ready, zero, op} = t[k][26:18];
            @(negedge clk);
            n_vec++;
            if (obs_a !== t[k][17:0]) begin
                n_err++; $display("FAIL lw row %0d: got %b want %b", k, obs_a, t[k][17:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_reset();
        logic [26:0] t [$];
        t.push_back({1'b1, 1'b0, 1'b0, c_sw, c_idle});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_madr});
        t.push_back({1'b0, 1'b0, 1'b0, c_sw, c_mwr});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_mwrd});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_sw, c_madr});
        t.push_back({1'b0, 1'b0, 1'b0, c_sw, c_mwr});
        t.push_back({1'b1, 1'b0, 1'b0, c_sw, c_idle});   // reset lands mid-write
        t.push_back({1'b0, 1'b0, 1'b0, c_sw, c_fw});
        foreach (t[k]) begin
            {reset, mem_ready, zero, op} = t[k][26:18];
            @(negedge clk);
            n_vec++;
            if (obs_a !== t[k][17:0]) begin
                n_err++; $display("FAIL sw row %0d: got %b want %b", k, obs_a, t[k][17:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [26:0] t [$];
        t.push_back({1'b1, 1'b0, 1'b0, c_beq, c_idle});
        t.push_back({1'b0, 1'b1, 1'b1, c_beq, c_fr});
        t.push_back({1'b0, 1'b1, 1'b1, c_beq, c_dec});
        t.push_back({1'b0, 1'b1, 1'b1, c_beq, c_brt});
        t.push_back({1'b0, 1'b1, 1'b1, c_bne, c_fr});
        t.push_back({1'b0, 1'b1, 1'b1, c_bne, c_dec});
        t.push_back({1'b0, 1'b1, 1'b1, c_bne, c_brn});
        t.push_back({1'b0, 1'b1, 1'b0, c_bne, c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_bne, c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_bne, c_brt});
        t.push_back({1'b0, 1'b1, 1'b0, c_beq, c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_beq, c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_beq, c_brn});
        t.push_back({1'b0, 1'b1, 1'b0, c_j,   c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_j,   c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_j,   c_jmp});
        t.push_back({1'b0, 1'b0, 1'b0, c_j,   c_fw});
        foreach (t[k]) begin
            {reset, mem_ready, zero, op} = t[k][26:18];
            @(negedge clk);
            n_vec++;
            if (obs_a !== t[k][17:0]) begin
                n_err++; $display("FAIL branch row %0d: got %b want %b", k, obs_a, t[k][17:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_immediate();
        logic [26:0] t [$];
        t.push_back({1'b1, 1'b0, 1'b0, c_addi, c_idle});
        t.push_back({1'b0, 1'b1, 1'b0, c_addi, c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_addi, c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_ori,  c_iadd});
        t.push_back({1'b0, 1'b1, 1'b0, c_ori,  c_iwb});
        t.push_back({1'b0, 1'b1, 1'b0, c_ori,  c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_ori,  c_dec});
        t.push_back({1'b0, 1'b1, 1'b0, c_addi, c_iori});
        t.push_back({1'b0, 1'b1, 1'b0, c_addi, c_iwb});
        t.push_back({1'b0, 1'b0, 1'b0, c_addi, c_fw});
        foreach (t[k]) begin
            {reset, mem_ready, zero, op} = t[k][26:18];
            @(negedge clk);
            n_vec++;
            if (obs_a !== t[k][17:0]) begin
                n_err++; $display("FAIL imm row %0d: got %b want %b", k, obs_a, t[k][17:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap();
        logic [26:0] t [$];
        t.push_back({1'b1, 1'b0, 1'b0, c_bad, c_idle});
        t.push_back({1'b0, 1'b1, 1'b0, c_bad, c_fr});
        t.push_back({1'b0, 1'b1, 1'b0, c_bad, c_dec});
        for (int i = 0; i < 20; i++) begin
            t.push_back({1'b0, 1'b1, i[0], c_lw, c_trp});
        end
        t.push_back({1'b1, 1'b1, 1'b0, c_lw, c_idle});
        t.push_back({1'b0, 1'b0, 1'b0, c_lw, c_fw});
        foreach (t[k]) begin
            {reset, mem_ready, zero, op} = t[k][26:18];
            @(negedge clk);
            n_vec++;
            if (obs_a !== t[k][17:0]) begin
                n_err++; $display("FAIL trap row %0d: got %b want %b", k, obs_a, t[k][17:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0;
        @(posedge clk); #1;
        test_reset();
        test_rtype_noready();
        test_lw_waits();
        test_sw_reset();
        test_branch_jump();
        test_immediate();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
